sel_sequencer: RTL and testbench

SEL_SEQUENCER -- requirements
Module: sel_sequencer

---
 rtl/sel_seq_pkg.sv | 11 +
 rtl/sel_sequencer_tick_gen.sv | 15 +
 rtl/sel_sequencer.sv | 93 +++++++++
 tb/tb_sel_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sel_seq_pkg.sv
// sel_seq_pkg: mode encodings and FSM state type shared by the select sequencer.
package sel_seq_pkg;
  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  localparam logic [2:0] SEL_MAX = 3'd7;
endpackage

// File: rtl/sel_sequencer_tick_gen.sv
// tick_gen: prescaler that pulses tick once every PRESCALE cycles while run is high.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  logic [15:0] cnt_q;
  assign tick = run && (cnt_q == 16'(PRESCALE - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (!run || tick) ? '0 : cnt_q + 16'd1;
endmodule

// File: rtl/sel_sequencer.sv
// sel_sequencer: prescaled 3-bit select scanner (up/down/pingpong/hold) with registered outputs.
// Optional one-hot decode of sel is built when SEL_SEQ_ONEHOT_EN is defined.
module sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic       step,
  output logic       wrap,
  output logic       busy,
  output logic [7:0] onehot
);
  state_e     state_q;
  logic [2:0] sel_q, sel_d;
  logic       dir_q, dir_d, wrap_d, step_q, wrap_q, up_mv, tick, go, adv;
  mode_e      mode_m;
  assign mode_m = mode_e'(mode);
  assign go     = (state_q == ST_IDLE) && start && !stop;
  assign adv    = tick && (mode_m != MODE_HOLD);
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  ((state_q == ST_RUN) && !stop),
    .tick (tick)
  );
  // Pingpong bounces off the ends so the end value is never repeated.
  always_comb begin
    up_mv  = dir_q ? (sel_q != SEL_MAX) : (sel_q == 3'd0);
    sel_d  = sel_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    case (mode_m)
      MODE_UP: begin
        sel_d  = sel_q + 3'd1;
        wrap_d = sel_q == SEL_MAX;
        dir_d  = 1'b1;
      end
      MODE_DOWN: begin
        sel_d  = sel_q - 3'd1;
        wrap_d = sel_q == 3'd0;
        dir_d  = 1'b0;
      end
      MODE_PINGPONG: begin
        sel_d  = up_mv ? sel_q + 3'd1 : sel_q - 3'd1;
        wrap_d = (sel_d == SEL_MAX) || (sel_d == 3'd0);
        dir_d  = (sel_d == SEL_MAX) ? 1'b0 : (sel_d == 3'd0) ? 1'b1 : up_mv;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (go) begin
        state_q <= ST_RUN;
        sel_q   <= '0;
        dir_q   <= 1'b1;
      end else if (state_q == ST_RUN && stop) begin
        state_q <= ST_IDLE;
      end else if (adv) begin
        sel_q  <= sel_d;
        dir_q  <= dir_d;
        step_q <= 1'b1;
        wrap_q <= wrap_d;
      end
    end
  assign sel  = sel_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign busy = state_q == ST_RUN;
`ifdef SEL_SEQ_ONEHOT_EN
  logic [7:0] onehot_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) onehot_q <= '0;
    else onehot_q <= go ? 8'h01 : adv ? 8'b1 << sel_d : onehot_q;
  assign onehot = onehot_q;
`else
  assign onehot = 8'h00;
`endif
endmodule

// File: tb/tb_sel_sequencer.sv
// tb_sel_sequencer: two instances (PRESCALE 4 and 1) checked every cycle against a behavioural model,
// plus hand-computed directed expectations.
module tb_sel_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] sel4, sel1;
  logic step4, step1, wrap4, wrap1, busy4, busy1;
  logic [7:0] oh4, oh1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sel_sequencer #(.PRESCALE(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .sel(sel4), .step(step4), .wrap(wrap4), .busy(busy4), .onehot(oh4));
  sel_sequencer #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .sel(sel1), .step(step1), .wrap(wrap1), .busy(busy1), .onehot(oh1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ps(input int i);
    return i == 0 ? 4 : 1;
  endfunction

  // Behavioural model: scan position, prescale count and direction per instance.
  int m_sel[2], m_cnt[2];
  bit m_run[2], m_dir[2], m_step[2], m_wrap[2], m_started[2];
  always @(posedge clk or negedge rst_n) begin
    int n;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_sel[i] = 0; m_cnt[i] = 0; m_dir[i] = 1;
        m_step[i] = 0; m_wrap[i] = 0; m_started[i] = 0;
      end else begin
        m_step[i] = 0; m_wrap[i] = 0;
        if (!m_run[i]) begin
          if (start && !stop) begin
            m_run[i] = 1; m_sel[i] = 0; m_cnt[i] = 0; m_dir[i] = 1; m_started[i] = 1;
          end
        end else if (stop) begin
          m_run[i] = 0; m_cnt[i] = 0;
        end else if (m_cnt[i] < ps(i) - 1) begin
          m_cnt[i]++;
        end else begin
          m_cnt[i] = 0;
          if (mode != 2'd3) begin
            if (mode == 2'd0) begin
              n = (m_sel[i] + 1) % 8; m_wrap[i] = (n == 0); m_dir[i] = 1;
            end else if (mode == 2'd1) begin
              n = (m_sel[i] + 7) % 8; m_wrap[i] = (n == 7); m_dir[i] = 0;
            end else begin
              n = m_dir[i] ? (m_sel[i] == 7 ? 6 : m_sel[i] + 1) : (m_sel[i] == 0 ? 1 : m_sel[i] - 1);
              m_wrap[i] = (n == 0) || (n == 7);
              m_dir[i] = (n == 7) ? 0 : (n == 0) ? 1 : (n > m_sel[i]);
            end
            m_sel[i] = n;
            m_step[i] = 1;
          end
        end
      end
    end
  end

  function automatic int exp_oh(input int i);
`ifdef SEL_SEQ_ONEHOT_EN
    return m_started[i] ? (1 << m_sel[i]) : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    chk("p4 sel", sel4, m_sel[0]);   chk("p1 sel", sel1, m_sel[1]);
    chk("p4 step", step4, m_step[0]); chk("p1 step", step1, m_step[1]);
    chk("p4 wrap", wrap4, m_wrap[0]); chk("p1 wrap", wrap1, m_wrap[1]);
    chk("p4 busy", busy4, m_run[0]);  chk("p1 busy", busy1, m_run[1]);
    chk("p4 onehot", oh4, exp_oh(0)); chk("p1 onehot", oh1, exp_oh(1));
  end

  int pp[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset sel", sel4, 0); chk("reset busy", busy4, 0);
    chk("reset step", step4, 0); chk("reset onehot", oh4, 0);
    // UP wrap, start on the first edge after release
    rst_n = 1; start = 1;
    @(negedge clk) start = 0;
    chk("start busy", busy4, 1); chk("start sel", sel4, 0);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) @(posedge clk);
      #1 chk("up no step", step4, 0);
      @(posedge clk);
      #1 chk("up sel", sel4, k % 8); chk("up step", step4, 1); chk("up wrap", wrap4, k == 8);
    end
    // reset mid-scan at sel=5
    repeat (20) @(posedge clk);
    #1 chk("pre-reset sel", sel4, 5);
    @(negedge clk) rst_n = 0;
    #1 chk("rst sel", sel4, 0); chk("rst busy", busy4, 0); chk("rst step", step4, 0);
    @(negedge clk) rst_n = 1;
    repeat (8) @(negedge clk);
    chk("post-rst busy", busy4, 0); chk("post-rst sel", sel4, 0);
    // start+stop together in IDLE, then in RUN
    start = 1; stop = 1;
    @(negedge clk) start = 0; stop = 0;
    chk("ss idle busy", busy4, 0);
    start = 1;
    @(negedge clk) start = 0;
    repeat (5) @(negedge clk);
    chk("ss run sel", sel4, 1);
    start = 1; stop = 1;
    @(negedge clk) start = 0; stop = 0;
    chk("ss stop busy", busy4, 0); chk("ss stop sel", sel4, 1);
    repeat (4) @(negedge clk);
    chk("ss frozen sel", sel4, 1); chk("ss frozen busy", busy4, 0);
    // UP->DOWN at sel=3 mid-prescale, then HOLD
    start = 1;
    @(negedge clk) start = 0;
    repeat (13) @(negedge clk);
    chk("mc sel3", sel4, 3);
    mode = 2'd1;
    repeat (3) @(posedge clk);
    #1 chk("mc down sel", sel4, 2); chk("mc down step", step4, 1);
    @(negedge clk) mode = 2'd3;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 chk("hold step", step4, 0); chk("hold sel", sel4, 2);
    end
    // PINGPONG on the PRESCALE=1 instance
    @(negedge clk) mode = 2'd2; stop = 1;
    @(negedge clk) stop = 0; start = 1;
    @(negedge clk) start = 0;
    chk("pp start sel", sel1, 0);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1 chk("pp sel", sel1, pp[k]); chk("pp wrap", wrap1, pp[k] == 0 || pp[k] == 7);
    end
    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = $urandom_range(0, 9) == 0;
      stop  = $urandom_range(0, 39) == 0;
      rst_n = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk) rst_n = 1; start = 0; stop = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
